// File: rtl/goertzel_peak_detect_if.sv
// Handshake bundle between the Goertzel bin engines, the peak detector and the verdict consumer.
// The master drives magnitudes and accepts verdicts; the slave is the peak detector.
interface goertzel_peak_detect_if #(
  parameter int DW = 32,
  parameter int IW = 4
);
  logic [DW-1:0] thr_i;
  logic          mag_valid;
  logic          mag_ready;
  logic [DW-1:0] mag_i;
  logic          det_valid;
  logic          det_ready;
  logic          det_hit;
  logic [IW-1:0] det_bin;
  logic [DW-1:0] det_mag;

  modport master (
    output thr_i, mag_valid, mag_i, det_ready,
    input  mag_ready, det_valid, det_hit, det_bin, det_mag
  );

  modport slave (
    input  thr_i, mag_valid, mag_i, det_ready,
    output mag_ready, det_valid, det_hit, det_bin, det_mag
  );
endinterface

// File: rtl/goertzel_peak_detect.sv
// Frame-wise dominant-tone decision over NF Goertzel bin magnitudes (peak, runner-up, threshold, ratio).
// Optional PEAK_DEBOUNCE_EN: report a hit only when the previous frame hit on the same bin.
module goertzel_peak_detect #(
  parameter int NF       = 11,
  parameter int DW       = 32,
  parameter int RATIO_SH = 2,
  parameter int IW       = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  goertzel_peak_detect_if.slave  bus
);

  localparam int WW = DW + RATIO_SH;
  localparam logic [IW-1:0] LAST_IDX = IW'(NF - 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DECIDE  = 2'd1,
    OUT     = 2'd2
  } state_t;

  state_t        state_r;
  logic [IW-1:0] cnt_r;
  logic [IW-1:0] idx1_r;
  logic [DW-1:0] max1_r;
  logic [DW-1:0] max2_r;
  logic [DW-1:0] thr_r;
  logic          mag_ready_r;
  logic          det_valid_r;
  logic          det_hit_r;
  logic [IW-1:0] det_bin_r;
  logic [DW-1:0] det_mag_r;

  logic          accept_s;
  logic [WW-1:0] max2_sh_s;
  logic          raw_hit_s;
  logic          rep_hit_s;

`ifdef PEAK_DEBOUNCE_EN
  logic          prev_hit_r;
  logic [IW-1:0] prev_bin_r;
`endif

  // Accept strobe and frame decision; the runner-up is widened before shifting so it cannot wrap.
  always_comb begin
    accept_s  = bus.mag_valid && mag_ready_r;
    max2_sh_s = WW'(max2_r) << RATIO_SH;
    raw_hit_s = (max1_r >= thr_r) && (max2_sh_s <= WW'(max1_r));
`ifdef PEAK_DEBOUNCE_EN
    rep_hit_s = raw_hit_s && prev_hit_r && (prev_bin_r == idx1_r);
`else
    rep_hit_s = raw_hit_s;
`endif
  end

  // Collect / decide / present state machine with registered handshake and verdict outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= COLLECT;
      cnt_r       <= {IW{1'b0}};
      idx1_r      <= {IW{1'b0}};
      max1_r      <= {DW{1'b0}};
      max2_r      <= {DW{1'b0}};
      thr_r       <= {DW{1'b0}};
      mag_ready_r <= 1'b1;
      det_valid_r <= 1'b0;
      det_hit_r   <= 1'b0;
      det_bin_r   <= {IW{1'b0}};
      det_mag_r   <= {DW{1'b0}};
`ifdef PEAK_DEBOUNCE_EN
      prev_hit_r  <= 1'b0;
      prev_bin_r  <= {IW{1'b0}};
`endif
    end else begin
      case (state_r)
        COLLECT: begin
          if (accept_s) begin
            if (cnt_r == {IW{1'b0}}) begin
              thr_r <= bus.thr_i;
            end
            // Strict compares: an equal magnitude never displaces the earlier peak, it becomes runner-up.
            if (bus.mag_i > max1_r) begin
              max2_r <= max1_r;
              max1_r <= bus.mag_i;
              idx1_r <= cnt_r;
            end else if (bus.mag_i > max2_r) begin
              max2_r <= bus.mag_i;
            end
            cnt_r <= cnt_r + IW'(1);
            if (cnt_r == LAST_IDX) begin
              state_r     <= DECIDE;
              mag_ready_r <= 1'b0;
            end
          end
        end
        DECIDE: begin
          det_hit_r   <= rep_hit_s;
          det_bin_r   <= idx1_r;
          det_mag_r   <= max1_r;
          det_valid_r <= 1'b1;
          state_r     <= OUT;
`ifdef PEAK_DEBOUNCE_EN
          prev_hit_r  <= raw_hit_s;
          prev_bin_r  <= idx1_r;
`endif
        end
        OUT: begin
          if (det_valid_r && bus.det_ready) begin
            det_valid_r <= 1'b0;
            cnt_r       <= {IW{1'b0}};
            idx1_r      <= {IW{1'b0}};
            max1_r      <= {DW{1'b0}};
            max2_r      <= {DW{1'b0}};
            mag_ready_r <= 1'b1;
            state_r     <= COLLECT;
          end
        end
        default: begin
          state_r     <= COLLECT;
          cnt_r       <= {IW{1'b0}};
          idx1_r      <= {IW{1'b0}};
          max1_r      <= {DW{1'b0}};
          max2_r      <= {DW{1'b0}};
          mag_ready_r <= 1'b1;
          det_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mag_ready = mag_ready_r;
  assign bus.det_valid = det_valid_r;
  assign bus.det_hit   = det_hit_r;
  assign bus.det_bin   = det_bin_r;
  assign bus.det_mag   = det_mag_r;

endmodule

// File: tb/tb_goertzel_peak_detect.sv
// Directed-vector bench for goertzel_peak_detect: a frame-level model predicts each verdict,
// one negedge process compares every presented verdict; a few literals pin the model.
module tb_goertzel_peak_detect;
  localparam int NF = 11;
  localparam int DW = 32;
  localparam int RS = 2;
  localparam int IW = 4;

  typedef logic [DW-1:0] frame_t [NF];
  typedef struct {
    logic          hit;
    logic [IW-1:0] bin;
    logic [DW-1:0] mag;
  } verdict_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  verdict_t expq[$];
  logic          mprev_hit = 1'b0;
  logic [IW-1:0] mprev_bin = '0;

  goertzel_peak_detect_if #(.DW(DW), .IW(IW)) bus ();

  goertzel_peak_detect #(.NF(NF), .DW(DW), .RATIO_SH(RS), .IW(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Frame of 'base' everywhere with up to two overridden bins (index -1 means none).
  function automatic frame_t mk(input logic [DW-1:0] base, input int i1, input logic [DW-1:0] v1,
                                input int i2, input logic [DW-1:0] v2);
    frame_t f;
    for (int i = 0; i < NF; i++) f[i] = base;
    if (i1 >= 0) f[i1] = v1;
    if (i2 >= 0) f[i2] = v2;
    return f;
  endfunction

  // Peak = largest value, lowest index among equals; runner-up = largest of the other bins.
  function automatic verdict_t model_raw(input frame_t f, input logic [DW-1:0] thr);
    verdict_t v;
    logic [DW-1:0] top = '0;
    logic [DW-1:0] second = '0;
    int idx = 0;
    for (int i = 0; i < NF; i++) if (f[i] > top) top = f[i];
    for (int i = NF - 1; i >= 0; i--) if (f[i] == top) idx = i;
    for (int j = 0; j < NF; j++) if (j != idx && f[j] > second) second = f[j];
    v.hit = (top >= thr) && ((64'(second) * (64'd1 << RS)) <= 64'(top));
    v.bin = IW'(idx);
    v.mag = top;
    return v;
  endfunction

  function automatic verdict_t model_frame(input frame_t f, input logic [DW-1:0] thr);
    verdict_t v;
    v = model_raw(f, thr);
`ifdef PEAK_DEBOUNCE_EN
    begin
      logic raw;
      raw = v.hit;
      v.hit = raw && mprev_hit && (mprev_bin == v.bin);
      mprev_hit = raw;
      mprev_bin = v.bin;
    end
`endif
    return v;
  endfunction

  // Every presented verdict must match the oldest outstanding prediction.
  always @(negedge clk) begin
    if (!rst && bus.det_valid) begin
      if (expq.size() == 0) begin
        chk("det_valid_without_frame", 64'(bus.det_valid), 64'd0);
      end else begin
        chk("det_hit", 64'(bus.det_hit), 64'(expq[0].hit));
        chk("det_bin", 64'(bus.det_bin), 64'(expq[0].bin));
        chk("det_mag", 64'(bus.det_mag), 64'(expq[0].mag));
        chk("mag_ready_while_out", 64'(bus.mag_ready), 64'd0);
        if (bus.det_ready) void'(expq.pop_front());
      end
    end
  end

  // Enter at posedge+1; leaves at posedge+1 right after the accepting edge.
  task automatic send_word(input logic [DW-1:0] d);
    int   w = 0;
    logic acc = 1'b0;
    bus.mag_valid = 1'b1;
    bus.mag_i     = d;
    while (!acc) begin
      @(negedge clk);
      acc = bus.mag_ready;
      @(posedge clk);
      #1;
      w++;
      if (!acc && w > 200) begin
        n_cmp++;
        n_bad++;
        $display("FAIL send_timeout: mag_ready low for %0d cycles, expected accept", w);
        acc = 1'b1;
      end
    end
    bus.mag_valid = 1'b0;
  endtask

  task automatic send_frame(input frame_t f, input logic [DW-1:0] thr, input int start,
                            output verdict_t v);
    bus.thr_i = thr;
    for (int i = start; i < NF; i++) send_word(f[i]);
    v = model_frame(f, thr);
    expq.push_back(v);
  endtask

  task automatic wait_drain();
    int w = 0;
    do begin
      @(posedge clk);
      w++;
    end while (expq.size() > 0 && w < 100);
    #1;
    chk("verdict_drain", 64'(expq.size()), 64'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_mag_ready"}, 64'(bus.mag_ready), 64'd1);
    chk({tag, "_det_valid"}, 64'(bus.det_valid), 64'd0);
    chk({tag, "_det_hit"},   64'(bus.det_hit),   64'd0);
    chk({tag, "_det_bin"},   64'(bus.det_bin),   64'd0);
    chk({tag, "_det_mag"},   64'(bus.det_mag),   64'd0);
  endtask

  localparam logic [DW-1:0] THR = 32'h0001_0000;

  initial begin
    frame_t   s1, s2, s3, s4b, zr, rx, rf, ov, tb1, p4;
    verdict_t v;
    int       t0;

    rst = 1'b1;
    bus.mag_valid = 1'b0;
    bus.mag_i     = '0;
    bus.thr_i     = '0;
    bus.det_ready = 1'b1;

    s1  = mk(32'h0000_1000, 5, 32'h0008_0000, -1, 32'h0);
    s2  = mk(32'h0, 3, 32'h0004_0000, 7, 32'h0002_0000);
    s3  = mk(32'h0, 2, 32'h0005_0000, 9, 32'h0005_0000);
    s4b = mk(32'h0000_0100, 6, 32'h0009_0000, 0, 32'h0000_0200);
    zr  = mk(32'h0, -1, 32'h0, -1, 32'h0);
    rx  = mk(32'h0, 10, 32'h0004_0000, 0, 32'h0001_0000);
    rf  = mk(32'h0, 0, 32'h0003_FFFF, 6, 32'h0001_0000);
    ov  = mk(32'h0, 4, 32'hFFFF_FFFF, 8, 32'h4000_0000);
    tb1 = mk(32'h0, 1, 32'h0001_0000, -1, 32'h0);
    p4  = mk(32'h0000_1000, 4, 32'h0008_0000, -1, 32'h0);

    // Hand-computed pins on the model itself.
    v = model_raw(s1, THR);
    chk("model_s1_hit", 64'(v.hit), 64'd1);
    chk("model_s1_bin", 64'(v.bin), 64'd5);
    chk("model_s1_mag", 64'(v.mag), 64'h0008_0000);
    v = model_raw(s2, THR);
    chk("model_s2_hit", 64'(v.hit), 64'd0);
    chk("model_s2_bin", 64'(v.bin), 64'd3);
    v = model_raw(s3, THR);
    chk("model_s3_hit", 64'(v.hit), 64'd0);
    chk("model_s3_bin", 64'(v.bin), 64'd2);
    v = model_raw(ov, THR);
    chk("model_ovf_hit", 64'(v.hit), 64'd0);
    v = model_raw(zr, 32'h0);
    chk("model_zero_thr0_hit", 64'(v.hit), 64'd1);
    v = model_raw(rx, THR);
    chk("model_ratio_exact_hit", 64'(v.hit), 64'd1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_state("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Scenario 1 with latency: DECIDE cycle shows nothing, verdict the cycle after.
    send_frame(s1, THR, 0, v);
    @(negedge clk);
    chk("latency_decide_cycle", 64'(bus.det_valid), 64'd0);
    @(negedge clk);
    chk("latency_out_cycle", 64'(bus.det_valid), 64'd1);
    wait_drain();

    send_frame(s2, THR, 0, v);
    wait_drain();
    send_frame(s3, THR, 0, v);
    wait_drain();

    // Back-to-back frames with det_ready high: NF+2 cycles per frame.
    t0 = cyc;
    send_frame(zr, 32'h0, 0, v);
    send_frame(zr, THR, 0, v);
    chk("throughput_cycles", 64'(cyc - t0), 64'(2 * NF + 2));
    wait_drain();

    send_frame(rx, THR, 0, v);
    wait_drain();
    send_frame(rf, THR, 0, v);
    wait_drain();
    send_frame(ov, THR, 0, v);
    wait_drain();
    send_frame(tb1, THR, 0, v);
    wait_drain();
    send_frame(tb1, 32'h0001_0001, 0, v);
    wait_drain();

    // Scenario 4: consumer stalls while upstream keeps offering the next frame's first word.
    bus.det_ready = 1'b0;
    send_frame(s1, THR, 0, v);
    bus.thr_i     = THR;
    bus.mag_valid = 1'b1;
    bus.mag_i     = s4b[0];
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k > 0) begin
        chk("stall_det_valid", 64'(bus.det_valid), 64'd1);
        chk("stall_mag_ready", 64'(bus.mag_ready), 64'd0);
      end
      @(posedge clk);
      #1;
    end
    bus.det_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("release_mag_ready", 64'(bus.mag_ready), 64'd1);
    chk("release_det_valid", 64'(bus.det_valid), 64'd0);
    @(posedge clk);
    #1;
    send_frame(s4b, THR, 1, v);
    wait_drain();

    // Scenario 5: reset mid-frame discards the partial frame.
    bus.thr_i = THR;
    for (int i = 0; i < 6; i++) send_word(s2[i]);
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk_reset_state("midframe_reset");
    expq.delete();
    mprev_hit = 1'b0;
    mprev_bin = '0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_frame(s1, THR, 0, v);
`ifdef PEAK_DEBOUNCE_EN
    chk("debounce_first_hit", 64'(v.hit), 64'd0);
`else
    chk("post_reset_s1_hit", 64'(v.hit), 64'd1);
`endif
    wait_drain();

    // Scenario 6 sequence (meaningful for the debounce build, plain repeats otherwise).
    send_frame(s1, THR, 0, v);
    chk("repeat_s1_hit", 64'(v.hit), 64'd1);
    wait_drain();
    send_frame(p4, THR, 0, v);
`ifdef PEAK_DEBOUNCE_EN
    chk("debounce_bin_change_hit", 64'(v.hit), 64'd0);
`else
    chk("p4_hit", 64'(v.hit), 64'd1);
`endif
    wait_drain();

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
